// File: rtl/mem_port_arbiter_if.sv
// Generic req/gnt/rvalid memory port bundle.
// The master drives the request channel, the slave answers with grant and response.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req;
   logic                  we;
   logic [DATA_W/8-1:0]   be;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;
   logic                  err;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between the fetch
// (instr) side and the load/store (data) side. One requester is selected per
// cycle and held until granted; a small in-order source-ID FIFO routes every
// response back to the side that issued it.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration; without
// it, data has fixed priority over instr.
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 2,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 clk,
   input  logic                 rstn,
   mem_port_arbiter_if.slave    instr,
   mem_port_arbiter_if.slave    data,
   mem_port_arbiter_if.master   mem,
   output logic [CNT_W-1:0]     outstanding_o,
   output logic                 proto_err_o
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   // Source IDs stored in the FIFO and used for the request mux.
   localparam logic ID_I = 1'b0;
   localparam logic ID_D = 1'b1;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      HOLD_I = 2'd1,
      HOLD_D = 2'd2
   } state_t;

   state_t                  state_reg;
   state_t                  state_next;
   logic                    sel_id;
   logic                    pick_id;
   logic                    mem_req;
   logic                    push;
   logic                    pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    head_id;
   logic [CNT_W-1:0]        count_reg;
   logic [CNT_W-1:0]        count_next;
   logic [PTR_W-1:0]        wr_ptr_reg;
   logic [PTR_W-1:0]        rd_ptr_reg;
   logic [MAX_OUTSTANDING-1:0] id_reg;
   logic [MAX_OUTSTANDING-1:0] id_next;
   logic                    proto_err_reg;

   // The instr side is read-only; its write fields are never looked at.
   logic unused_instr_fields;
   assign unused_instr_fields = ^{instr.we, instr.be, instr.wdata};

`ifdef MEM_ARB_RR_EN
   // 1 = data wins the next simultaneous request, 0 = instr wins.
   logic rr_data_next_reg;

   // Round-robin choice on contention, otherwise the sole requester.
   always_comb begin
      pick_id = data.req ? ID_D : ID_I;
      if (instr.req && data.req) begin
         pick_id = rr_data_next_reg ? ID_D : ID_I;
      end
   end

   // After each granted transaction, point at the side that was not served.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr_data_next_reg <= 1'b1;
      end else if (push) begin
         rr_data_next_reg <= (sel_id == ID_I);
      end
   end
`else
   // Fixed priority: data beats instr whenever it requests.
   always_comb begin
      pick_id = data.req ? ID_D : ID_I;
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= ARB;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state, selection and request generation; a full FIFO gates the
   // request off but keeps any held choice so it resumes after a drain.
   always_comb begin
      state_next = state_reg;
      sel_id     = ID_I;
      mem_req    = 1'b0;
      case (state_reg)
         ARB: begin
            sel_id = pick_id;
            if (!fifo_full && (instr.req || data.req)) begin
               mem_req = 1'b1;
               if (!mem.gnt) begin
                  state_next = (pick_id == ID_D) ? HOLD_D : HOLD_I;
               end
            end
         end
         HOLD_I: begin
            sel_id = ID_I;
            if (!fifo_full) begin
               mem_req = 1'b1;
               if (mem.gnt) begin
                  state_next = ARB;
               end
            end
         end
         HOLD_D: begin
            sel_id = ID_D;
            if (!fifo_full) begin
               mem_req = 1'b1;
               if (mem.gnt) begin
                  state_next = ARB;
               end
            end
         end
         default: begin
            state_next = ARB;
         end
      endcase
   end

   // Request channel: mux of the selected side, instr forced to a full-word read.
   assign mem.req   = mem_req;
   assign mem.we    = (sel_id == ID_D) ? data.we    : 1'b0;
   assign mem.be    = (sel_id == ID_D) ? data.be    : '1;
   assign mem.addr  = (sel_id == ID_D) ? data.addr  : instr.addr;
   assign mem.wdata = (sel_id == ID_D) ? data.wdata : '0;

   assign instr.gnt = mem_req & mem.gnt & (sel_id == ID_I);
   assign data.gnt  = mem_req & mem.gnt & (sel_id == ID_D);

   // FIFO bookkeeping; a response with nothing outstanding is never popped.
   assign push       = mem_req & mem.gnt;
   assign pop        = mem.rvalid & ~fifo_empty;
   assign fifo_full  = (count_reg == CNT_W'(MAX_OUTSTANDING));
   assign fifo_empty = (count_reg == '0);
   assign head_id    = id_reg[rd_ptr_reg];

   // Per-entry write: only the slot at the write pointer takes the new ID.
   generate
      for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_id_entry
         assign id_next[gi] = (push && (wr_ptr_reg == PTR_W'(gi))) ? sel_id : id_reg[gi];
      end
   endgenerate

   // Outstanding count: simultaneous push and pop cancel out.
   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   // FIFO storage and wrapping pointers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         id_reg     <= '0;
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         id_reg    <= id_next;
         count_reg <= count_next;
         if (push) begin
            wr_ptr_reg <= (wr_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= (rd_ptr_reg == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_reg + 1'b1;
         end
      end
   end

   // Sticky flag for a response that had no matching request.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         proto_err_reg <= 1'b0;
      end else if (mem.rvalid && fifo_empty) begin
         proto_err_reg <= 1'b1;
      end
   end

   // Response routing: rvalid qualified by the FIFO head, data/err broadcast.
   assign instr.rvalid = mem.rvalid & ~fifo_empty & (head_id == ID_I);
   assign data.rvalid  = mem.rvalid & ~fifo_empty & (head_id == ID_D);
   assign instr.rdata  = mem.rdata;
   assign data.rdata   = mem.rdata;
   assign instr.err    = mem.err;
   assign data.err     = mem.err;

   assign outstanding_o = count_reg;
   assign proto_err_o   = proto_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after the rising
// edge, outputs are checked 3 ns after it; expected values are hand-computed.
module tb_mem_port_arbiter;

   logic       clk;
   logic       rstn;
   logic [1:0] outstanding;
   logic       proto_err;

   int n_asserts = 0;
   int n_fail    = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) instr_bus ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

   mem_port_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .MAX_OUTSTANDING(2)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .instr         (instr_bus),
      .data          (data_bus),
      .mem           (mem_bus),
      .outstanding_o (outstanding),
      .proto_err_o   (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      instr_bus.req   = 1'b0;
      instr_bus.we    = 1'b0;
      instr_bus.be    = 4'h0;
      instr_bus.addr  = 32'h0;
      instr_bus.wdata = 32'h0;
      data_bus.req    = 1'b0;
      data_bus.we     = 1'b0;
      data_bus.be     = 4'h0;
      data_bus.addr   = 32'h0;
      data_bus.wdata  = 32'h0;
      mem_bus.gnt     = 1'b0;
      mem_bus.rvalid  = 1'b0;
      mem_bus.rdata   = 32'h0;
      mem_bus.err     = 1'b0;
   endtask

   // One line per memory-port transaction (request handshake or response).
   always @(negedge clk) begin
      if (rstn && mem_bus.req && mem_bus.gnt)
         $display("txn req  addr=0x%08h we=%0b be=0x%0h wdata=0x%08h", mem_bus.addr, mem_bus.we, mem_bus.be, mem_bus.wdata);
      if (rstn && mem_bus.rvalid)
         $display("txn resp rdata=0x%08h err=%0b i_rvalid=%0b d_rvalid=%0b", mem_bus.rdata, mem_bus.err, instr_bus.rvalid, data_bus.rvalid);
   end

   // Stimulus rule: a requester left waiting by a stalled port keeps its inputs stable.
   logic        stall_prev = 1'b0;
   logic [31:0] i_addr_prev, d_addr_prev, d_wdata_prev;
   logic        i_req_prev, d_req_prev, d_we_prev;
   always @(negedge clk) begin
      if (rstn && stall_prev) begin
         assert ({instr_bus.req, instr_bus.addr, data_bus.req, data_bus.we, data_bus.addr, data_bus.wdata}
                 === {i_req_prev, i_addr_prev, d_req_prev, d_we_prev, d_addr_prev, d_wdata_prev})
         else $error("FAIL stimulus_hold: requester inputs changed during a stall");
      end
      stall_prev   <= rstn && mem_bus.req && !mem_bus.gnt;
      i_req_prev   <= instr_bus.req;
      i_addr_prev  <= instr_bus.addr;
      d_req_prev   <= data_bus.req;
      d_we_prev    <= data_bus.we;
      d_addr_prev  <= data_bus.addr;
      d_wdata_prev <= data_bus.wdata;
   end

   logic [3:0] exp_d;

   initial begin
`ifdef MEM_ARB_RR_EN
      exp_d = 4'b0101;
`else
      exp_d = 4'b1111;
`endif
      rstn = 1'b0;
      idle();

      // Reset state
      #3;
      check("rst_outstanding", 32'(outstanding), 32'd0);
      check("rst_proto_err",   32'(proto_err),   32'd0);
      check("rst_mem_req",     32'(mem_bus.req), 32'd0);
      check("rst_gnts",        32'({instr_bus.gnt, data_bus.gnt}), 32'd0);
      check("rst_rvalids",     32'({instr_bus.rvalid, data_bus.rvalid}), 32'd0);
      cyc();
      cyc();
      rstn = 1'b1;

      // Single fetch
      cyc();
      instr_bus.req = 1'b1; instr_bus.addr = 32'h100; mem_bus.gnt = 1'b1;
      settle();
      check("fetch_igmt",  32'(instr_bus.gnt), 32'd1);
      check("fetch_dgnt",  32'(data_bus.gnt),  32'd0);
      check("fetch_req",   32'(mem_bus.req),   32'd1);
      check("fetch_addr",  mem_bus.addr,       32'h100);
      check("fetch_we_be", 32'({mem_bus.we, mem_bus.be}), 32'h0F);
      cyc();
      instr_bus.req = 1'b0; mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h13;
      settle();
      check("fetch_outst",   32'(outstanding),      32'd1);
      check("fetch_irvalid", 32'(instr_bus.rvalid), 32'd1);
      check("fetch_drvalid", 32'(data_bus.rvalid),  32'd0);
      check("fetch_rdata",   instr_bus.rdata,       32'h13);
      cyc();
      mem_bus.rvalid = 1'b0;
      settle();
      check("fetch_drain", 32'(outstanding), 32'd0);

      // Both request for 4 granted cycles
      for (int i = 0; i < 4; i++) begin
         cyc();
         instr_bus.req = 1'b1; instr_bus.addr = 32'h300;
         data_bus.req  = 1'b1; data_bus.addr  = 32'h400; data_bus.be = 4'h3;
         mem_bus.gnt = 1'b1; mem_bus.rvalid = (i > 0); mem_bus.rdata = 32'(i);
         settle();
         check($sformatf("both_dgnt%0d", i), 32'(data_bus.gnt),  32'(exp_d[i]));
         check($sformatf("both_ignt%0d", i), 32'(instr_bus.gnt), 32'(!exp_d[i]));
         check($sformatf("both_addr%0d", i), mem_bus.addr, exp_d[i] ? 32'h400 : 32'h300);
         if (i > 0)
            check($sformatf("both_route%0d", i), 32'({instr_bus.rvalid, data_bus.rvalid}),
                  exp_d[i-1] ? 32'd1 : 32'd2);
      end
      cyc();
      idle();
      mem_bus.rvalid = 1'b1;
      settle();
      check("both_route4", 32'({instr_bus.rvalid, data_bus.rvalid}), exp_d[3] ? 32'd1 : 32'd2);
      cyc();
      mem_bus.rvalid = 1'b0;
      settle();
      check("both_drain", 32'(outstanding), 32'd0);

      // Stall: store held for 3 cycles while instr also requests
      cyc();
      data_bus.req = 1'b1; data_bus.we = 1'b1; data_bus.addr = 32'h200; data_bus.be = 4'hF;
      data_bus.wdata = 32'hDEADBEEF;
      instr_bus.req = 1'b1; instr_bus.addr = 32'h104;
      mem_bus.gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check($sformatf("stall_addr%0d", k), mem_bus.addr, 32'h200);
         check($sformatf("stall_we%0d", k),   32'(mem_bus.we), 32'd1);
         check($sformatf("stall_req%0d", k),  32'(mem_bus.req), 32'd1);
         check($sformatf("stall_gnts%0d", k), 32'({instr_bus.gnt, data_bus.gnt}), 32'd0);
         cyc();
      end
      mem_bus.gnt = 1'b1;
      settle();
      check("stall_dgnt",  32'({instr_bus.gnt, data_bus.gnt}), 32'd1);
      check("stall_wdata", mem_bus.wdata, 32'hDEADBEEF);
      cyc();
      data_bus.req = 1'b0; data_bus.we = 1'b0;
      settle();
      check("stall_ignt",  32'({instr_bus.gnt, data_bus.gnt}), 32'd2);
      check("stall_iaddr", mem_bus.addr, 32'h104);
      check("stall_iwe",   32'(mem_bus.we), 32'd0);
      cyc();
      idle();
      mem_bus.rvalid = 1'b1;
      settle();
      check("stall_resp_d", 32'({instr_bus.rvalid, data_bus.rvalid}), 32'd1);
      cyc();
      settle();
      check("stall_resp_i", 32'({instr_bus.rvalid, data_bus.rvalid}), 32'd2);
      cyc();
      mem_bus.rvalid = 1'b0;
      settle();
      check("stall_drain", 32'(outstanding), 32'd0);

      // Full: two fetches outstanding blocks the third
      cyc();
      instr_bus.req = 1'b1; instr_bus.addr = 32'h500; mem_bus.gnt = 1'b1;
      settle();
      check("full_gnt0", 32'(instr_bus.gnt), 32'd1);
      cyc();
      instr_bus.addr = 32'h504;
      settle();
      check("full_gnt1", 32'(instr_bus.gnt), 32'd1);
      cyc();
      instr_bus.addr = 32'h508;
      settle();
      check("full_outst",  32'(outstanding),   32'd2);
      check("full_req",    32'(mem_bus.req),   32'd0);
      check("full_gnt2",   32'(instr_bus.gnt), 32'd0);
      cyc();
      mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hA;
      settle();
      check("full_req_pop", 32'(mem_bus.req),      32'd0);
      check("full_irvalid", 32'(instr_bus.rvalid), 32'd1);
      cyc();
      mem_bus.rvalid = 1'b0;
      settle();
      check("full_resume_req", 32'(mem_bus.req),   32'd1);
      check("full_resume_gnt", 32'(instr_bus.gnt), 32'd1);
      check("full_resume_addr", mem_bus.addr,      32'h508);
      check("full_resume_outst", 32'(outstanding), 32'd1);
      cyc();
      idle();
      mem_bus.rvalid = 1'b1;
      cyc();
      cyc();
      mem_bus.rvalid = 1'b0;
      settle();
      check("full_drain", 32'(outstanding), 32'd0);

      // Routing: I then D, error on the second response
      cyc();
      instr_bus.req = 1'b1; instr_bus.addr = 32'h600; mem_bus.gnt = 1'b1;
      settle();
      check("route_ignt", 32'(instr_bus.gnt), 32'd1);
      cyc();
      instr_bus.req = 1'b0;
      data_bus.req = 1'b1; data_bus.addr = 32'h700; data_bus.be = 4'hF;
      settle();
      check("route_dgnt", 32'(data_bus.gnt), 32'd1);
      cyc();
      idle();
      mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h11; mem_bus.err = 1'b0;
      settle();
      check("route_r1",     32'({instr_bus.rvalid, data_bus.rvalid}), 32'd2);
      check("route_r1_err", 32'(instr_bus.err), 32'd0);
      cyc();
      mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h22; mem_bus.err = 1'b1;
      settle();
      check("route_r2",       32'({instr_bus.rvalid, data_bus.rvalid}), 32'd1);
      check("route_r2_err",   32'(data_bus.err), 32'd1);
      check("route_r2_rdata", data_bus.rdata,    32'h22);
      cyc();
      idle();
      settle();
      check("route_drain", 32'(outstanding), 32'd0);
      check("route_noperr", 32'(proto_err),  32'd0);

      // Spurious response with empty FIFO
      cyc();
      mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h55;
      settle();
      check("spur_rvalids", 32'({instr_bus.rvalid, data_bus.rvalid}), 32'd0);
      check("spur_perr_now", 32'(proto_err), 32'd0);
      cyc();
      mem_bus.rvalid = 1'b0;
      settle();
      check("spur_perr_set", 32'(proto_err), 32'd1);
      cyc();
      settle();
      check("spur_perr_sticky", 32'(proto_err), 32'd1);
      rstn = 1'b0;
      #1;
      check("spur_perr_rst", 32'(proto_err), 32'd0);
      cyc();
      rstn = 1'b1;

      // Reset mid-operation: late response counts as spurious
      cyc();
      instr_bus.req = 1'b1; instr_bus.addr = 32'h800; mem_bus.gnt = 1'b1;
      settle();
      check("midrst_gnt", 32'(instr_bus.gnt), 32'd1);
      cyc();
      idle();
      settle();
      check("midrst_outst1", 32'(outstanding), 32'd1);
      rstn = 1'b0;
      #1;
      check("midrst_outst0", 32'(outstanding), 32'd0);
      cyc();
      rstn = 1'b1;
      cyc();
      mem_bus.rvalid = 1'b1;
      settle();
      check("midrst_late_rvalid", 32'({instr_bus.rvalid, data_bus.rvalid}), 32'd0);
      cyc();
      mem_bus.rvalid = 1'b0;
      settle();
      check("midrst_late_perr", 32'(proto_err), 32'd1);

      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
